// File: rtl/mmi_pkg.sv
// mmi_multi shared definitions
// address map, status bits, word helpers
package mmi_pkg;

  localparam logic [7:0] ADDR_CMD         = 8'h00;
  localparam logic [7:0] ADDR_SEL         = 8'h01;
  localparam logic [7:0] ADDR_STATUS      = 8'h03;
  localparam logic [7:0] ADDR_SNAP_BASE   = 8'h08;
  localparam logic [7:0] ADDR_MISC_BASE   = 8'h10;
  localparam logic [7:0] ADDR_SHADOW_BASE = 8'h80;

  localparam int STATUS_BAD_CMD = 0;
  localparam int STATUS_BAD_SEL = 1;

  function automatic int bytes_per_word(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/mmi_shadow_word.sv
// one output word: byte-writable shadow
// plus live register updated on commit
module mmi_shadow_word
  import mmi_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W/8-1:0]  byte_we,
  input  logic [7:0]           wdata,
  input  logic                 commit,
  output logic [DATA_W-1:0]    shadow,
  output logic [DATA_W-1:0]    live
);

  localparam int BPW = bytes_per_word(DATA_W);

  // shadow bytes take CPU writes; live copies shadow on commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
      live   <= '0;
    end else begin
      for (int b = 0; b < BPW; b++) begin
        if (byte_we[b]) shadow[8*b +: 8] <= wdata;
      end
      if (commit) live <= shadow;
    end
  end

endmodule

// File: rtl/mmi_multi.sv
// CPU byte bus bridge: shadowed outputs,
// strobes, input snapshot and misc ports
module mmi_multi
  import mmi_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int N_OUT    = 2,
  parameter int N_IN     = 32,
  parameter int N_STROBE = 32,
  parameter int N_MISC   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               cpu_addr,
  input  logic [7:0]               cpu_data_in,
  input  logic                     wr,
  input  logic                     rd,
  output logic [7:0]               cpu_data_out,
  output logic [N_OUT*DATA_W-1:0]  data_out,
  output logic [N_STROBE-1:0]      set,
  input  logic [N_IN*DATA_W-1:0]   inputs,
  input  logic [N_MISC*8-1:0]      misc_in,
  output logic [N_MISC*8-1:0]      misc_out
);

  localparam int BPW = bytes_per_word(DATA_W);

  logic [DATA_W-1:0]       snapshot;
  logic [DATA_W-1:0]       snap_next;
  logic [7:0]              sel;
  logic [1:0]              status;
  logic [1:0]              status_clr;
  logic [N_STROBE-1:0]     set_next;
  logic [N_OUT-1:0]        commit;
  logic [N_OUT*DATA_W-1:0] shadow_all;
  logic [7:0]              rdata;
  logic cmd_wr, sel_wr, status_wr;
  logic bad_cmd, bad_sel;
  logic hit_sel, hit_status;
  logic hit_snap, hit_misc, hit_shadow;

  assign cmd_wr    = wr && (cpu_addr == ADDR_CMD);
  assign sel_wr    = wr && (cpu_addr == ADDR_SEL);
  assign status_wr = wr && (cpu_addr == ADDR_STATUS);

  assign hit_sel    = cpu_addr == ADDR_SEL;
  assign hit_status = cpu_addr == ADDR_STATUS;
  assign hit_snap   = cpu_addr[7:2] == ADDR_SNAP_BASE[7:2];
  assign hit_misc   = cpu_addr[7:4] == ADDR_MISC_BASE[7:4];
  assign hit_shadow = cpu_addr[7];

  // CMD decode: strobe one-hot, commit, bad index
  always_comb begin
    set_next = '0;
    commit   = '0;
    for (int s = 0; s < N_STROBE; s++) begin
      set_next[s] = cmd_wr && (cpu_data_in == 8'(s));
    end
    for (int j = 0; j < N_OUT; j++) begin
      commit[j] = cmd_wr && (cpu_data_in == 8'(j));
    end
    bad_cmd = cmd_wr && ({24'd0, cpu_data_in} >= N_STROBE);
  end

  // SEL decode: pick the addressed input word
  always_comb begin
    snap_next = '0;
    for (int n = 0; n < N_IN; n++) begin
      if (cpu_data_in == 8'(n))
        snap_next = inputs[n*DATA_W +: DATA_W];
    end
    bad_sel = sel_wr && ({24'd0, cpu_data_in} >= N_IN);
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_word
    logic [BPW-1:0] we;

    // byte enables for this word's shadow
    always_comb begin
      we = '0;
      for (int b = 0; b < BPW; b++) begin
        we[b] = wr && hit_shadow
             && (cpu_addr[6:2] == 5'(j))
             && (cpu_addr[1:0] == 2'(b));
      end
    end

    mmi_shadow_word #(
      .DATA_W (DATA_W)
    ) u_word (
      .clk     (clk),
      .reset   (reset),
      .byte_we (we),
      .wdata   (cpu_data_in),
      .commit  (commit[j]),
      .shadow  (shadow_all[j*DATA_W +: DATA_W]),
      .live    (data_out[j*DATA_W +: DATA_W])
    );
  end

  // read mux over current (pre-write) state
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_sel:    rdata = sel;
      hit_status: rdata = {6'd0, status};
      hit_snap: begin
        for (int b = 0; b < BPW; b++) begin
          if (cpu_addr[1:0] == 2'(b))
            rdata = snapshot[8*b +: 8];
        end
      end
      hit_misc: begin
        for (int n = 0; n < N_MISC; n++) begin
          if (cpu_addr[3:0] == 4'(n))
            rdata = misc_in[8*n +: 8];
        end
      end
      hit_shadow: begin
        for (int j = 0; j < N_OUT; j++) begin
          for (int b = 0; b < BPW; b++) begin
            if (cpu_addr[6:2] == 5'(j) &&
                cpu_addr[1:0] == 2'(b))
              rdata = shadow_all[j*DATA_W + 8*b +: 8];
          end
        end
      end
      default: rdata = '0;
    endcase
  end

  assign status_clr = status_wr ? cpu_data_in[1:0] : 2'b00;

  // strobes, selection, snapshot and sticky status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set      <= '0;
      sel      <= '0;
      snapshot <= '0;
      status   <= '0;
    end else begin
      set <= set_next;
      if (sel_wr) begin
        sel      <= cpu_data_in;
        snapshot <= snap_next;
      end
      status <= (status & ~status_clr)
              | {bad_sel, bad_cmd};
    end
  end

  // misc output bytes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misc_out <= '0;
    end else begin
      for (int n = 0; n < N_MISC; n++) begin
        if (wr && hit_misc &&
            cpu_addr[3:0] == 4'(n))
          misc_out[8*n +: 8] <= cpu_data_in;
      end
    end
  end

  // registered read data, held between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cpu_data_out <= '0;
    else if (rd) cpu_data_out <= rdata;
  end

endmodule
